// File: rtl/alu_reservation_station_if.sv
// Issue, CDB, ALU and result-broadcast signals of the ALU reservation station.
// The slave side is the station; the master side drives issue/CDB/ALU return.
interface alu_reservation_station_if #(
  parameter int ROB_WIDTH = 4,
  parameter int RS_WIDTH  = 2
);
  logic                 clear;
  logic                 issue_valid;
  logic [3:0]           issue_op;
  logic [31:0]          issue_vj;
  logic                 issue_qj_valid;
  logic [ROB_WIDTH-1:0] issue_qj;
  logic [31:0]          issue_vk;
  logic                 issue_qk_valid;
  logic [ROB_WIDTH-1:0] issue_qk;
  logic [ROB_WIDTH-1:0] issue_rob_tag;
  logic                 full;
  logic                 cdb_valid;
  logic [ROB_WIDTH-1:0] cdb_tag;
  logic [31:0]          cdb_value;
  logic                 cal;
  logic [31:0]          a;
  logic [31:0]          b;
  logic [3:0]           alu_op;
  logic [RS_WIDTH-1:0]  to_alu_index;
  logic                 alu_done;
  logic [RS_WIDTH-1:0]  alu_index;
  logic [31:0]          alu_result;
  logic                 out_valid;
  logic [ROB_WIDTH-1:0] out_rob_tag;
  logic [31:0]          out_value;

  modport master (
    output clear, issue_valid, issue_op,
    output issue_vj, issue_qj_valid, issue_qj,
    output issue_vk, issue_qk_valid, issue_qk,
    output issue_rob_tag,
    output cdb_valid, cdb_tag, cdb_value,
    output alu_done, alu_index, alu_result,
    input  full, cal, a, b, alu_op, to_alu_index,
    input  out_valid, out_rob_tag, out_value
  );

  modport slave (
    input  clear, issue_valid, issue_op,
    input  issue_vj, issue_qj_valid, issue_qj,
    input  issue_vk, issue_qk_valid, issue_qk,
    input  issue_rob_tag,
    input  cdb_valid, cdb_tag, cdb_value,
    input  alu_done, alu_index, alu_result,
    output full, cal, a, b, alu_op, to_alu_index,
    output out_valid, out_rob_tag, out_value
  );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds decoded ops, wakes operands from the CDB,
// dispatches one ready op per cycle and rebroadcasts ALU results by ROB tag.
module alu_reservation_station #(
  parameter int ROB_WIDTH = 4,
  parameter int RS_WIDTH  = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  alu_reservation_station_if.slave bus
);

  localparam int N = 1 << RS_WIDTH;

  typedef logic [ROB_WIDTH-1:0] tag_t;
  typedef logic [RS_WIDTH-1:0]  idx_t;

  typedef struct packed {
    logic        busy;
    logic        exec;
    logic [3:0]  op;
    logic [31:0] vj;
    logic        qjv;
    tag_t        qj;
    logic [31:0] vk;
    logic        qkv;
    tag_t        qk;
    tag_t        tag;
  } ent_t;

  ent_t        ent_q [N];
  ent_t        ent_d [N];
  ent_t        new_e;

  logic        cal_q, cal_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  op_q, op_d;
  idx_t        idx_q, idx_d;
  logic        ov_q, ov_d;
  tag_t        otag_q, otag_d;
  logic [31:0] oval_q, oval_d;

  logic        full;
  idx_t        free_idx;
  logic        rdy_found;
  idx_t        rdy_idx;
  logic        done_ok;

  // Descending scan so the lowest index wins.
  always_comb begin
    full      = 1'b1;
    free_idx  = '0;
    rdy_found = 1'b0;
    rdy_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!ent_q[i].busy) begin
        full     = 1'b0;
        free_idx = idx_t'(i);
      end
      if (ent_q[i].busy && !ent_q[i].exec &&
          !ent_q[i].qjv && !ent_q[i].qkv) begin
        rdy_found = 1'b1;
        rdy_idx   = idx_t'(i);
      end
    end
  end

  always_comb begin
    new_e      = '0;
    new_e.busy = 1'b1;
    new_e.op   = bus.issue_op;
    new_e.vj   = bus.issue_vj;
    new_e.qjv  = bus.issue_qj_valid;
    new_e.qj   = bus.issue_qj;
    new_e.vk   = bus.issue_vk;
    new_e.qkv  = bus.issue_qk_valid;
    new_e.qk   = bus.issue_qk;
    new_e.tag  = bus.issue_rob_tag;
    if (bus.cdb_valid && bus.issue_qj_valid &&
        bus.issue_qj == bus.cdb_tag) begin
      new_e.vj  = bus.cdb_value;
      new_e.qjv = 1'b0;
    end
    if (bus.cdb_valid && bus.issue_qk_valid &&
        bus.issue_qk == bus.cdb_tag) begin
      new_e.vk  = bus.cdb_value;
      new_e.qkv = 1'b0;
    end
  end

  assign done_ok = bus.alu_done &&
                   ent_q[bus.alu_index].busy &&
                   ent_q[bus.alu_index].exec;

  always_comb begin
    ent_d  = ent_q;
    cal_d  = 1'b0;
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    idx_d  = idx_q;
    ov_d   = 1'b0;
    otag_d = otag_q;
    oval_d = oval_q;
    if (bus.clear) begin
      for (int i = 0; i < N; i++) begin
        ent_d[i].busy = 1'b0;
        ent_d[i].exec = 1'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.cdb_valid && ent_q[i].busy) begin
          if (ent_q[i].qjv && ent_q[i].qj == bus.cdb_tag) begin
            ent_d[i].vj  = bus.cdb_value;
            ent_d[i].qjv = 1'b0;
          end
          if (ent_q[i].qkv && ent_q[i].qk == bus.cdb_tag) begin
            ent_d[i].vk  = bus.cdb_value;
            ent_d[i].qkv = 1'b0;
          end
        end
      end
      if (rdy_found) begin
        cal_d = 1'b1;
        a_d   = ent_q[rdy_idx].vj;
        b_d   = ent_q[rdy_idx].vk;
        op_d  = ent_q[rdy_idx].op;
        idx_d = rdy_idx;
        ent_d[rdy_idx].exec = 1'b1;
      end
      if (done_ok) begin
        ov_d   = 1'b1;
        otag_d = ent_q[bus.alu_index].tag;
        oval_d = bus.alu_result;
        ent_d[bus.alu_index].busy = 1'b0;
        ent_d[bus.alu_index].exec = 1'b0;
      end
      if (bus.issue_valid && !full) begin
        ent_d[free_idx] = new_e;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < N; i++) begin
        ent_q[i] <= '0;
      end
      cal_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      idx_q  <= '0;
      ov_q   <= 1'b0;
      otag_q <= '0;
      oval_q <= '0;
    end else if (rdy_in) begin
      ent_q  <= ent_d;
      cal_q  <= cal_d;
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      idx_q  <= idx_d;
      ov_q   <= ov_d;
      otag_q <= otag_d;
      oval_q <= oval_d;
    end
  end

  assign bus.full         = full;
  assign bus.cal          = cal_q;
  assign bus.a            = a_q;
  assign bus.b            = b_q;
  assign bus.alu_op       = op_q;
  assign bus.to_alu_index = idx_q;
  assign bus.out_valid    = ov_q;
  assign bus.out_rob_tag  = otag_q;
  assign bus.out_value    = oval_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: one-cycle ALU model plus a result
// scoreboard checked whenever the station broadcasts.
module tb_alu_reservation_station;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] val;
  } res_t;

  res_t sb[$];

  alu_reservation_station_if #(.ROB_WIDTH(4), .RS_WIDTH(2)) bus ();

  alu_reservation_station #(.ROB_WIDTH(4), .RS_WIDTH(2)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_f(input logic [3:0] op,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    unique case (op)
      4'b0000: alu_f = x + y;
      4'b0001: alu_f = x - y;
      default: alu_f = x ^ y;
    endcase
  endfunction

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bus.alu_done   <= 1'b0;
      bus.alu_index  <= '0;
      bus.alu_result <= '0;
    end else if (rdy_in) begin
      bus.alu_done   <= bus.cal;
      bus.alu_index  <= bus.to_alu_index;
      bus.alu_result <= alu_f(bus.alu_op, bus.a, bus.b);
    end
  end

  always @(posedge clk_in) begin
    logic rs;
    res_t e;
    rs = rdy_in;
    #1;
    if (!rst_in && rs && bus.out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("out_tag", bus.out_rob_tag, e.tag);
        chk("out_val", bus.out_value, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [3:0] op,
                       input logic [31:0] vj, input logic qjv,
                       input logic [3:0] qj,
                       input logic [31:0] vk, input logic qkv,
                       input logic [3:0] qk, input logic [3:0] tag);
    bus.issue_op       = op;
    bus.issue_vj       = vj;
    bus.issue_qj_valid = qjv;
    bus.issue_qj       = qj;
    bus.issue_vk       = vk;
    bus.issue_qk_valid = qkv;
    bus.issue_qk       = qk;
    bus.issue_rob_tag  = tag;
    bus.issue_valid    = 1'b1;
    tick();
    bus.issue_valid    = 1'b0;
  endtask

  task automatic cdb(input logic v, input logic [3:0] t,
                     input logic [31:0] val);
    bus.cdb_valid = v;
    bus.cdb_tag   = t;
    bus.cdb_value = val;
  endtask

  task automatic push(input logic [3:0] t, input logic [31:0] v);
    res_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic fill_blocked();
    for (int i = 0; i < 4; i++) begin
      issue(4'b0000, 0, 1'b1, 4'(12 + i), i, 1'b0, 4'd0, 4'(i));
      if (i == 2) chk("full_at3", bus.full, 0);
    end
    chk("full_at4", bus.full, 1);
  endtask

  initial begin
    bus.clear       = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_op    = '0;
    bus.issue_vj    = '0;
    bus.issue_qj_valid = 1'b0;
    bus.issue_qj    = '0;
    bus.issue_vk    = '0;
    bus.issue_qk_valid = 1'b0;
    bus.issue_qk    = '0;
    bus.issue_rob_tag = '0;
    cdb(1'b0, 4'd0, 32'd0);

    repeat (2) tick();
    rst_in = 1'b0;
    chk("rst_cal", bus.cal, 0);
    chk("rst_ov", bus.out_valid, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_a", bus.a, 0);
    chk("rst_otag", bus.out_rob_tag, 0);

    // ADD both ready
    push(4'd3, 32'd12);
    issue(4'b0000, 5, 1'b0, 4'd0, 7, 1'b0, 4'd0, 4'd3);
    tick();
    chk("add_cal", bus.cal, 1);
    chk("add_a", bus.a, 5);
    chk("add_b", bus.b, 7);
    chk("add_op", bus.alu_op, 0);
    chk("add_idx", bus.to_alu_index, 0);
    tick();
    chk("add_cal_off", bus.cal, 0);
    repeat (2) tick();

    // SUB waiting on tag 9
    push(4'd5, 32'd18);
    issue(4'b0001, 0, 1'b1, 4'd9, 2, 1'b0, 4'd0, 4'd5);
    tick();
    tick();
    chk("sub_wait", bus.cal, 0);
    cdb(1'b1, 4'd9, 32'd20);
    tick();
    cdb(1'b0, 4'd0, 32'd0);
    chk("sub_nodisp", bus.cal, 0);
    tick();
    chk("sub_cal", bus.cal, 1);
    chk("sub_a", bus.a, 20);
    chk("sub_b", bus.b, 2);
    chk("sub_op", bus.alu_op, 1);
    repeat (3) tick();

    // issue-time CDB bypass
    push(4'd6, 32'd0);
    cdb(1'b1, 4'd4, 32'hFFFF_FFFF);
    issue(4'b0000, 1, 1'b0, 4'd0, 0, 1'b1, 4'd4, 4'd6);
    cdb(1'b0, 4'd0, 32'd0);
    tick();
    chk("byp_cal", bus.cal, 1);
    chk("byp_b", bus.b, 32'hFFFF_FFFF);
    repeat (3) tick();

    // fill, reject 5th, free entry 2
    fill_blocked();
    issue(4'b0000, 1, 1'b0, 4'd0, 1, 1'b0, 4'd0, 4'd7);
    chk("full_hold", bus.full, 1);
    tick();
    chk("rej_nocal", bus.cal, 0);
    push(4'd2, 32'd102);
    cdb(1'b1, 4'd14, 32'd100);
    tick();
    cdb(1'b0, 4'd0, 32'd0);
    tick();
    chk("e2_cal", bus.cal, 1);
    chk("e2_idx", bus.to_alu_index, 2);
    chk("e2_full1", bus.full, 1);
    tick();
    chk("e2_full2", bus.full, 1);
    tick();
    chk("e2_freed", bus.full, 0);
    push(4'd8, 32'd7);
    issue(4'b0000, 3, 1'b0, 4'd0, 4, 1'b0, 4'd0, 4'd8);
    chk("refill_full", bus.full, 1);
    tick();
    chk("refill_cal", bus.cal, 1);
    chk("refill_idx", bus.to_alu_index, 2);
    repeat (2) tick();
    chk("refill_free", bus.full, 0);

    // clear on the alu_done cycle
    cdb(1'b1, 4'd12, 32'd1);
    tick();
    cdb(1'b1, 4'd13, 32'd1);
    tick();
    cdb(1'b0, 4'd0, 32'd0);
    chk("clr_cal0", bus.to_alu_index, 0);
    tick();
    chk("clr_cal1", bus.to_alu_index, 1);
    chk("clr_done_in", bus.alu_done, 1);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clr_ov", bus.out_valid, 0);
    chk("clr_cal", bus.cal, 0);
    chk("clr_full", bus.full, 0);
    tick();
    chk("clr_ov2", bus.out_valid, 0);

    // freeze with rdy_in low
    fill_blocked();
    cdb(1'b1, 4'd12, 32'd50);
    tick();
    cdb(1'b0, 4'd0, 32'd0);
    tick();
    chk("frz_pre_cal", bus.cal, 1);
    push(4'd0, 32'd50);
    rdy_in = 1'b0;
    bus.clear = 1'b1;
    bus.issue_valid = 1'b1;
    cdb(1'b1, 4'd13, 32'd9);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("frz_cal", bus.cal, 1);
      chk("frz_a", bus.a, 50);
      chk("frz_full", bus.full, 1);
      chk("frz_ov", bus.out_valid, 0);
    end
    rdy_in = 1'b1;
    bus.clear = 1'b0;
    bus.issue_valid = 1'b0;
    cdb(1'b0, 4'd0, 32'd0);
    tick();
    chk("unfrz_cal", bus.cal, 0);
    tick();
    chk("unfrz_ov", bus.out_valid, 1);
    chk("unfrz_full", bus.full, 0);
    tick();
    chk("unfrz_e1wait", bus.cal, 0);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;

    // async reset mid-dispatch
    issue(4'b0000, 1, 1'b0, 4'd0, 1, 1'b0, 4'd0, 4'd9);
    tick();
    chk("rstd_cal_pre", bus.cal, 1);
    #2;
    rst_in = 1'b1;
    #1;
    chk("rstd_cal", bus.cal, 0);
    chk("rstd_ov", bus.out_valid, 0);
    chk("rstd_full", bus.full, 0);
    tick();
    rst_in = 1'b0;
    repeat (4) tick();
    chk("sb_empty", 64'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
Reservation station feeding the integer ALU. It holds up to 2^RS_WIDTH decoded ALU/branch ops and captures operand values from the CDB. It dispatches one ready op per cycle to the ALU on the cal/a/b/alu_op/index interface, and accepts the ALU's to_rs/to_rs_index/result return. Each completed result is broadcast with its ROB tag toward the ROB/CDB arbiter.

Parameters:
ROB_WIDTH, 4, width of ROB tags (operand dependencies and destination).
RS_WIDTH, 2, entry-index width; 4 entries.

Ports:
clk_in  in  1  clock
rst_in  in  1  asynchronous reset, active-high
rdy_in  in  1  global ready; low freezes all state
clear  in  1  mispredict flush (effective only when rdy_in=1)
issue_valid  in  1  allocate a new entry this cycle
issue_op  in  4  ALU opcode (codebase alu_* encoding)
issue_vj  in  32  operand A value (valid when issue_qj_valid=0)
issue_qj_valid  in  1  operand A is pending
issue_qj  in  ROB_WIDTH  ROB tag producing A
issue_vk  in  32  operand B value
issue_qk_valid  in  1  operand B is pending
issue_qk  in  ROB_WIDTH  ROB tag producing B
issue_rob_tag  in  ROB_WIDTH  destination ROB tag
full  out  1  all entries busy (combinational)
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  ROB_WIDTH  CDB tag
cdb_value  in  32  CDB value
cal  out  1  dispatch strobe to ALU (registered)
a  out  32  operand A to ALU
b  out  32  operand B to ALU
alu_op  out  4  opcode to ALU
to_alu_index  out  RS_WIDTH  entry index sent with dispatch
alu_done  in  1  ALU result valid (ALU to_rs)
alu_index  in  RS_WIDTH  entry index returned (ALU to_rs_index)
alu_result  in  32  ALU result
out_valid  out  1  result broadcast valid (registered)
out_rob_tag  out  ROB_WIDTH  destination tag of the result
out_value  out  32  result value

Behaviour:
- Reset: all entries not busy. cal=0, out_valid=0, a=b=0, alu_op=0, to_alu_index=0, out_rob_tag=0, out_value=0.
- Priority at each posedge: rst_in, then (rdy_in=0: hold everything, cal and out_valid hold), then clear, then normal operation.
- clear: all entries freed; cal<=0, out_valid<=0. An alu_done arriving in the same cycle is dropped.
- Entry state: busy, executing, op, vj, qj_valid, qj, vk, qk_valid, qk, rob_tag.
- States per entry: FREE -> WAIT (on issue) -> EXEC (on dispatch) -> FREE (on alu_done with matching index).
- full = all entries busy, computed from current state. issue_valid while full is ignored; a same-cycle free does not admit it.
- Allocation: lowest-index FREE entry.
- Issue bypass: if cdb_valid and the tag matches an issuing pending operand, that operand is stored with cdb_value and marked not pending.
- Wakeup: each cycle, every busy entry whose qj_valid/qk_valid is set and whose qj/qk equals cdb_tag (with cdb_valid=1) latches cdb_value and clears the pending flag.
- Ready entry: busy, not executing, qj_valid=0, qk_valid=0.
- Dispatch: the lowest-index ready entry is selected. Next edge: cal<=1 with a, b, alu_op, to_alu_index registered from it, and the entry is marked executing. With no ready entry, cal<=0.
- An entry that becomes ready through this cycle's wakeup is dispatchable no earlier than the next cycle.
- Latency: dispatch at edge N, ALU result at edge N+1 (alu_done), broadcast at edge N+2 (out_valid=1 for one cycle). The entry is FREE and allocatable from edge N+2. Throughput is one op per cycle.
- Result return: on alu_done, out_valid<=1, out_rob_tag<=rob_tag[alu_index], out_value<=alu_result, and the entry is freed.
- alu_done for a non-executing index is ignored (out_valid<=0).
- Simultaneous issue, dispatch, wakeup and free in one cycle are all legal and must act on distinct entries.
- Operands are 32-bit and unmodified; the RS does no arithmetic.

Test Plan:
- Reset asserted mid-dispatch -> cal=0, out_valid=0, full=0 immediately (async), with no later spurious result.
- Issue ADD vj=5, vk=7, tag=3, both ready -> cal=1 with a=5, b=7, alu_op=0000 next cycle. With the ALU model, out_valid=1, out_rob_tag=3, out_value=12 two cycles after cal.
- Issue SUB with qj pending on tag 9 and vk=2; three cycles later cdb_valid, tag 9, value 20 -> cal asserted one cycle after the CDB cycle with a=20, b=2; final out_value=18.
- Issue with qk=4 while cdb broadcasts tag 4 value 0xFFFF_FFFF in the same cycle -> entry captures b=0xFFFF_FFFF and dispatches next cycle.
- Issue 4 dependent-blocked ops -> full=1, and a 5th issue is ignored. Free one via CDB then ALU -> full drops on the broadcast edge, and the next issue lands in the freed index.
- Two ready entries plus clear asserted on the cycle alu_done returns -> no out_valid, all entries free. With rdy_in=0 for 3 cycles, outputs and entries stay frozen.
